// File: rtl/softmax_norm_if.sv
// Signal bundle for softmax_norm: score input stream, probability output stream, status.
interface softmax_norm_if;
  logic [7:0] s_data;
  logic       s_vld;
  logic       s_rdy;
  logic [7:0] m_data;
  logic       m_vld;
  logic       m_rdy;
  logic       m_last;
  logic       busy;

  modport slave (
    input  s_data, s_vld, m_rdy,
    output s_rdy, m_data, m_vld, m_last, busy
  );

  modport master (
    output s_data, s_vld, m_rdy,
    input  s_rdy, m_data, m_vld, m_last, busy
  );
endinterface

// File: rtl/softmax_norm.sv
// Buffers a row of N UQ3.5 exp scores, then emits each divided by the row sum as UQ0.8,
// using a bit-serial restoring divider (one quotient bit per cycle).
//
// state   | meaning
// COLLECT | accepting scores, accumulating sum
// DIVIDE  | 16-step shift-subtract of (buf[idx]<<8)/sum
// EMIT    | holding a probability until the downstream handshake
module softmax_norm #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  softmax_norm_if.slave bus
);
  localparam int SUM_W = 8 + $clog2(N);
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {COLLECT, DIVIDE, EMIT} state_t;

  state_t           state;
  logic [7:0]       buf_mem [N];
  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] idx;
  logic [SUM_W:0]   rem;
  logic [15:0]      num;
  logic [3:0]       step_cnt;

  logic             s_rdy;
  logic [7:0]       m_data;
  logic             m_vld;
  logic             m_last;
  logic             busy;

  logic [SUM_W:0]   rem_sh;
  logic [SUM_W:0]   rem_nx;
  logic [15:0]      num_nx;
  logic [7:0]       q_sat;
  logic [IDX_W-1:0] idx_inc;

  // num doubles as the quotient register: numerator bits shift out the top, quotient bits in the bottom
  always_comb begin
    rem_sh  = {rem[SUM_W-1:0], num[15]};
    rem_nx  = rem_sh;
    num_nx  = {num[14:0], 1'b0};
    if (rem_sh >= {1'b0, sum}) begin
      rem_nx = rem_sh - {1'b0, sum};
      num_nx = {num[14:0], 1'b1};
    end
    q_sat = num_nx[7:0];
    if (sum == '0)
      q_sat = 8'h00;
    else if (|num_nx[15:8])
      q_sat = 8'hFF;
    idx_inc = idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= COLLECT;
      s_rdy    <= 1'b1;
      m_vld    <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= 8'h00;
      busy     <= 1'b0;
      sum      <= '0;
      idx      <= '0;
      rem      <= '0;
      num      <= '0;
      step_cnt <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.s_vld && s_rdy) begin
            buf_mem[idx] <= bus.s_data;
            sum          <= sum + SUM_W'(bus.s_data);
            if (idx == LAST_IDX) begin
              idx      <= '0;
              state    <= DIVIDE;
              s_rdy    <= 1'b0;
              busy     <= 1'b1;
              num      <= {buf_mem[0], 8'h00};
              rem      <= '0;
              step_cnt <= 4'd15;
            end else begin
              idx <= idx_inc;
            end
          end
        end
        DIVIDE: begin
          rem <= rem_nx;
          num <= num_nx;
          if (step_cnt == 4'd0) begin
            m_data <= q_sat;
            m_vld  <= 1'b1;
            m_last <= (idx == LAST_IDX);
            state  <= EMIT;
          end else begin
            step_cnt <= step_cnt - 4'd1;
          end
        end
        EMIT: begin
          if (bus.m_rdy) begin
            m_vld  <= 1'b0;
            m_last <= 1'b0;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              sum   <= '0;
              state <= COLLECT;
              s_rdy <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx      <= idx_inc;
              num      <= {buf_mem[idx_inc], 8'h00};
              rem      <= '0;
              step_cnt <= 4'd15;
              state    <= DIVIDE;
            end
          end
        end
        default: begin
          state <= COLLECT;
          s_rdy <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_rdy  = s_rdy;
  assign bus.m_data = m_data;
  assign bus.m_vld  = m_vld;
  assign bus.m_last = m_last;
  assign bus.busy   = busy;
endmodule

// File: tb/tb_softmax_norm.sv
// Random and directed rows through softmax_norm, checked against a plain-arithmetic
// probability model with latency, backpressure and mid-row reset cases.
module tb_softmax_norm;
  logic clk = 1'b0;
  logic rst_n;

  softmax_norm_if bus ();

  softmax_norm #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] row [4];
  int         stall [4];
  bit         hold_svld;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_prob(input int score, input int total);
    int q;
    if (total == 0) return 0;
    q = (score * 256) / total;
    return (q > 255) ? 255 : q;
  endfunction

  // Offers the four scores of row[]; returns at the negedge just after the final accept.
  task automatic push_row();
    for (int i = 0; i < 4; i++) begin
      int t = 0;
      bus.s_data = row[i];
      bus.s_vld  = 1'b1;
      while (!bus.s_rdy && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!bus.s_rdy) chk("s_rdy_wait", t, 0);
      @(negedge clk);
    end
    bus.s_vld  = 1'b0;
    bus.s_data = 8'h00;
  endtask

  // Collects n_out outputs, starting at the negedge one cycle after the triggering edge.
  task automatic pull_row(input int n_out);
    int total = 0;
    for (int i = 0; i < 4; i++) total += row[i];
    if (hold_svld) begin
      bus.s_vld  = 1'b1;
      bus.s_data = 8'h77;
    end
    for (int k = 0; k < n_out; k++) begin
      int lat = 1;
      int exp_d = ref_prob(row[k], total);
      bus.m_rdy = (stall[k] == 0);
      chk("busy_in_div", bus.busy, 1);
      chk("s_rdy_in_div", bus.s_rdy, 0);
      while (!bus.m_vld && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      chk("latency", lat, 17);
      chk("m_data", bus.m_data, exp_d);
      chk("m_last", bus.m_last, (k == 3) ? 1 : 0);
      if (stall[k] > 0) begin
        repeat (stall[k]) @(negedge clk);
        chk("stall_vld", bus.m_vld, 1);
        chk("stall_data", bus.m_data, exp_d);
        chk("stall_last", bus.m_last, (k == 3) ? 1 : 0);
        chk("stall_s_rdy", bus.s_rdy, 0);
        bus.m_rdy = 1'b1;
      end
      @(negedge clk);
      if (k == 3) begin
        bus.s_vld  = 1'b0;
        bus.s_data = 8'h00;
        chk("end_s_rdy", bus.s_rdy, 1);
        chk("end_busy", bus.busy, 0);
        chk("end_m_vld", bus.m_vld, 0);
      end
    end
    bus.m_rdy = 1'b1;
  endtask

  task automatic run_row(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    row[0] = a; row[1] = b; row[2] = c; row[3] = d;
    push_row();
    pull_row(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    bus.s_vld  = 1'b0;
    bus.s_data = 8'h00;
    bus.m_rdy  = 1'b1;
    hold_svld  = 1'b0;
    for (int i = 0; i < 4; i++) stall[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_s_rdy", bus.s_rdy, 1);
    chk("rst_m_vld", bus.m_vld, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_row(8'h20, 8'h20, 8'h20, 8'h20);
    run_row(8'h60, 8'h20, 8'h00, 8'h00);
    run_row(8'hFF, 8'h00, 8'h00, 8'h00);
    run_row(8'h00, 8'h00, 8'h00, 8'h00);
    run_row(8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // backpressure on element 2 with a stale s_vld held through the whole output phase
    stall[2]  = 5;
    hold_svld = 1'b1;
    run_row(8'h30, 8'h10, 8'h40, 8'h80);
    stall[2]  = 0;
    hold_svld = 1'b0;
    run_row(8'h20, 8'h20, 8'h20, 8'h20);

    // abort during the divide of element 2
    row[0] = 8'h90; row[1] = 8'h05; row[2] = 8'h33; row[3] = 8'h01;
    push_row();
    pull_row(2);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_s_rdy", bus.s_rdy, 1);
    chk("abort_m_vld", bus.m_vld, 0);
    chk("abort_busy", bus.busy, 0);
    run_row(8'h20, 8'h20, 8'h20, 8'h20);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 4; i++) begin
        row[i]   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        stall[i] = int'($urandom_range(0, 3));
      end
      hold_svld = ($urandom_range(0, 1) == 1);
      push_row();
      pull_row(4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/softmax_norm.md
Name: softmax_norm

Overview:
- Downstream stage of the attention MAC + e^x datapath.
- Collects a row of N exponentiated scores (UQ3.5, 8-bit) over a valid/ready stream and accumulates their sum.
- Emits each score divided by the row sum as a UQ0.8 probability over a master valid/ready stream.
- Uses a bit-serial restoring divider, one quotient bit per cycle, so area stays within tile budget.

Parameters:
- N, 4, scores per row; legal range 2..16.
- SUM_W, 8+$clog2(N), accumulator width (derived; must not be overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low. Clock is clk.
- s_data  in  8  exp score, UQ3.5
- s_vld  in  1  upstream valid
- s_rdy  out  1  ready to accept score
- m_data  out  8  normalized probability, UQ0.8
- m_vld  out  1  output valid
- m_rdy  in  1  downstream ready
- m_last  out  1  high with the N-th output of a row
- busy  out  1  high in any state other than COLLECT

Behaviour:
- Reset (rst_n=0 at a clk edge) puts the block in COLLECT with:
  - s_rdy=1; m_vld=0, m_last=0, m_data=0x00, busy=0.
  - sum=0, idx=0, divider regs=0, buffer contents don't-care.
- Reset mid-operation aborts the row; partial buffer, sum and divider state are discarded.
- State machine is COLLECT -> DIVIDE -> EMIT -> (DIVIDE | COLLECT).
- COLLECT:
  - s_rdy=1. On s_vld&s_rdy: buf[idx]<=s_data; sum<=sum+s_data (SUM_W bits, cannot overflow); idx++.
  - On the accept with idx==N-1: idx<=0 and go to DIVIDE.
- DIVIDE:
  - s_rdy=0. Computes q=floor((buf[idx]<<8)/sum) with a 16-step restoring shift-subtract, one step per cycle.
  - Numerator is 16 bits, remainder is SUM_W+1 bits.
  - After exactly 16 cycles, latch m_data=sat8(q) and go to EMIT.
  - Saturation: q>=256 (only when buf[idx]==sum, i.e. a sole nonzero score) gives 0xFF.
  - sum==0: all 16 cycles still run, result forced to 0x00.
- EMIT:
  - m_vld=1; m_last=(idx==N-1). m_data, m_last and m_vld stay stable until m_rdy.
  - On m_vld&m_rdy with idx<N-1: idx++, go to DIVIDE.
  - On m_vld&m_rdy with idx==N-1: clear sum and idx, go to COLLECT. s_rdy=1 in the next cycle.
- Latency:
  - First m_vld is high in the 17th cycle after the clock edge that accepted the N-th input.
  - Each subsequent element becomes valid 17 cycles after the previous output handshake when m_rdy is held high.
- Beats and handshakes:
  - s_vld while s_rdy=0 is ignored; upstream must hold it.
  - There is no input/output overlap: a new row is accepted only after the final output handshake.
  - m_rdy is a don't-care outside EMIT.
  - s_vld and m_rdy asserted in the same cycle: only the handshake valid in the current state takes effect.
- Rounding: truncation (floor). The sum of a row's outputs may be below 256 by up to N-1 LSB.
- m_vld is registered; no combinational path from m_rdy or s_vld to any output.

Test Plan:
- Uniform row: N=4, inputs 0x20,0x20,0x20,0x20 with m_rdy=1.
  - Outputs 0x40,0x40,0x40,0x40; m_last only on the 4th.
  - First m_vld 17 cycles after the 4th accept.
- Skewed row: inputs 0x60,0x20,0x00,0x00 (sum 0x80) -> outputs 0xC0,0x40,0x00,0x00.
- Saturation and zero sum:
  - Inputs 0xFF,0x00,0x00,0x00 -> 0xFF,0x00,0x00,0x00.
  - Inputs all 0x00 -> four outputs of 0x00, no hang.
- Max-width sum: inputs all 0xFF (sum 0x3FC) -> four outputs 0x40; no accumulator overflow.
- Backpressure:
  - Hold m_rdy=0 for 5 cycles during EMIT -> m_data and m_last stable, m_vld stays 1, idx does not advance.
  - s_vld held high during DIVIDE/EMIT -> s_rdy=0 and no extra accepts; the next row starts cleanly after m_last.
- Reset mid-operation:
  - Assert rst_n=0 for 1 cycle during DIVIDE of element 2 -> next cycle s_rdy=1, m_vld=0, busy=0.
  - A following row 0x20 x4 yields 0x40 x4, with no residue from the aborted row.
